// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared types and lookups for the UART configuration decoder
// Holds the parser state encoding, the baud table with its divisor function,
// the data-width and stop-length decoders, and the ack response codes.
package uart_cfg_pkg;
  typedef enum logic [2:0] {S_H0, S_H1, S_CH, S_CHI, S_CLO, S_CKS, S_TAIL} state_t;
  localparam int BAUD_TAB [16] = '{110, 300, 600, 1200, 2400, 4800, 9600, 14400,
                                   19200, 38400, 43000, 56000, 57600, 115200, 128000, 256000};
  localparam logic [7:0] ACK_OK  = 8'hAC;
  localparam logic [7:0] ACK_CKS = 8'hE1;
  localparam logic [7:0] ACK_CH  = 8'hE2;
  localparam logic [7:0] ACK_TO  = 8'hE3;
  // Each entry divides by a constant, so this folds to a 16-way constant mux.
  function automatic logic [15:0] bps_div_of(input int clk_hz, input logic [3:0] sel);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) if (sel == 4'(k)) r = 16'(clk_hz / (16 * BAUD_TAB[k]));
    return r;
  endfunction
  function automatic logic [3:0] data_size_of(input logic [1:0] f);
    return 4'd5 + {2'b00, f};
  endfunction
  function automatic logic [5:0] stop_size_of(input logic [1:0] f);
    return f == 2'd1 ? 6'd24 : f == 2'd2 ? 6'd32 : 6'd16;
  endfunction
endpackage

// File: rtl/uart_cfg_channel.sv
// uart_cfg_channel: per-channel pending config with busy-gated apply
// Ports: i_clk, i_rst_n (async active-low); i_load accepts i_cfg into pending;
// i_busy holds off apply; o_bps_div/o_data_size/o_stop_size/o_parity_mode are
// the live config; o_cfg_update pulses the cycle the live config is loaded.
module uart_cfg_channel import uart_cfg_pkg::*; #(
  parameter int CLK_HZ = 50000000,
  parameter int DEFAULT_BAUD_SEL = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_busy,
  input  logic [27:0] i_cfg,
  output logic [15:0] o_bps_div,
  output logic [3:0]  o_data_size,
  output logic [5:0]  o_stop_size,
  output logic [1:0]  o_parity_mode,
  output logic        o_cfg_update
);
  localparam logic [27:0] DEF = {bps_div_of(CLK_HZ, 4'(DEFAULT_BAUD_SEL)), 4'd8, 6'd16, 2'd0};
  logic [27:0] r_pcfg, r_cfg;
  logic r_pend, r_upd;
  logic w_pend, w_apply;
  logic [27:0] w_next;
  // A fresh accept bypasses the pending register so it can apply the same cycle.
  assign w_pend  = r_pend | i_load;
  assign w_apply = w_pend & ~i_busy;
  assign w_next  = i_load ? i_cfg : r_pcfg;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pcfg <= DEF;
      r_cfg  <= DEF;
      r_pend <= 1'b0;
      r_upd  <= 1'b0;
    end else begin
      if (i_load) r_pcfg <= i_cfg;
      r_pend <= w_pend & i_busy;
      r_upd  <= w_apply;
      if (w_apply) r_cfg <= w_next;
    end
  assign {o_bps_div, o_data_size, o_stop_size, o_parity_mode} = r_cfg;
  assign o_cfg_update = r_upd;
endmodule

// File: rtl/uart_cfg_mux_decoder.sv
// uart_cfg_mux_decoder: framed UART config command parser for NUM_CH channels
// Ports: i_clk, i_rst_n (async active-low); i_rx_data/i_rx_valid byte stream;
// i_ch_busy per-channel hold-off; i_err_clear clears sticky errors;
// o_bps_div/o_data_size/o_stop_size/o_parity_mode packed per channel;
// o_cfg_update per-channel pulse; o_frame_ok accept pulse; o_err_* sticky flags.
// Option UART_CFG_ACK_EN adds o_ack_data/o_ack_valid/i_ack_ready response port.
module uart_cfg_mux_decoder import uart_cfg_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CLK_HZ = 50000000,
  parameter int DEFAULT_BAUD_SEL = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55,
  parameter logic [7:0] TAIL = 8'h55
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic [NUM_CH-1:0]     i_ch_busy,
  input  logic                  i_err_clear,
  output logic [16*NUM_CH-1:0]  o_bps_div,
  output logic [4*NUM_CH-1:0]   o_data_size,
  output logic [6*NUM_CH-1:0]   o_stop_size,
  output logic [2*NUM_CH-1:0]   o_parity_mode,
  output logic [NUM_CH-1:0]     o_cfg_update,
  output logic                  o_frame_ok,
  output logic                  o_err_checksum,
  output logic                  o_err_channel,
  output logic                  o_err_timeout
`ifdef UART_CFG_ACK_EN
  ,
  output logic [7:0]            o_ack_data,
  output logic                  o_ack_valid,
  input  logic                  i_ack_ready
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t r_st, w_nxt;
  logic [7:0] r_ch, r_hi, r_lo, r_cks;
  logic [TW-1:0] r_tcnt;
  logic r_frame_ok, r_err_cks, r_err_ch, r_err_to;
  logic w_tail, w_cks_ok, w_ch_ok, w_acc, w_set_cks, w_set_ch, w_to;
  logic [27:0] w_cfg;
  assign w_tail    = i_rx_valid && r_st == S_TAIL && i_rx_data == TAIL;
  assign w_cks_ok  = 8'(r_ch + r_hi + r_lo) == r_cks;
  assign w_ch_ok   = r_ch < 8'(NUM_CH);
  assign w_acc     = w_tail && w_cks_ok && w_ch_ok;
  assign w_set_cks = w_tail && !w_cks_ok;
  assign w_set_ch  = w_tail && w_cks_ok && !w_ch_ok;
  assign w_to      = r_st != S_H0 && !i_rx_valid && r_tcnt == TW'(TIMEOUT_CYC - 1);
  assign w_cfg     = {bps_div_of(CLK_HZ, r_hi[3:0]), data_size_of(r_lo[5:4]),
                      stop_size_of(r_lo[3:2]), r_lo[1:0]};
  // HDR0 seen where HDR1 or TAIL was expected may start a new frame.
  always_comb
    w_nxt = r_st == S_H0   ? (i_rx_data == HDR0 ? S_H1 : S_H0) :
            r_st == S_H1   ? (i_rx_data == HDR1 ? S_CH : i_rx_data == HDR0 ? S_H1 : S_H0) :
            r_st == S_TAIL ? (i_rx_data == TAIL ? S_H0 : i_rx_data == HDR0 ? S_H1 : S_H0) :
                             state_t'(r_st + 3'd1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_st       <= S_H0;
      r_ch       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cks      <= '0;
      r_tcnt     <= '0;
      r_frame_ok <= 1'b0;
      r_err_cks  <= 1'b0;
      r_err_ch   <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_st <= w_to ? S_H0 : i_rx_valid ? w_nxt : r_st;
      if (i_rx_valid && r_st == S_CH) r_ch <= i_rx_data;
      if (i_rx_valid && r_st == S_CHI) r_hi <= i_rx_data;
      if (i_rx_valid && r_st == S_CLO) r_lo <= i_rx_data;
      if (i_rx_valid && r_st == S_CKS) r_cks <= i_rx_data;
      r_tcnt     <= (i_rx_valid || r_st == S_H0) ? '0 : r_tcnt + 1'b1;
      r_frame_ok <= w_acc;
      r_err_cks  <= w_set_cks | (r_err_cks & ~i_err_clear);
      r_err_ch   <= w_set_ch | (r_err_ch & ~i_err_clear);
      r_err_to   <= w_to | (r_err_to & ~i_err_clear);
    end
  assign o_frame_ok     = r_frame_ok;
  assign o_err_checksum = r_err_cks;
  assign o_err_channel  = r_err_ch;
  assign o_err_timeout  = r_err_to;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_cfg_channel #(.CLK_HZ(CLK_HZ), .DEFAULT_BAUD_SEL(DEFAULT_BAUD_SEL)) u_ch (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_load(w_acc && r_ch == 8'(i)),
      .i_busy(i_ch_busy[i]),
      .i_cfg(w_cfg),
      .o_bps_div(o_bps_div[16*i +: 16]),
      .o_data_size(o_data_size[4*i +: 4]),
      .o_stop_size(o_stop_size[6*i +: 6]),
      .o_parity_mode(o_parity_mode[2*i +: 2]),
      .o_cfg_update(o_cfg_update[i])
    );
  end
`ifdef UART_CFG_ACK_EN
  logic [7:0] r_ack_data;
  logic r_ack_valid;
  logic w_ack_evt;
  logic [7:0] w_ack_code;
  assign w_ack_evt  = w_acc | w_set_cks | w_set_ch | w_to;
  assign w_ack_code = w_to ? ACK_TO : w_acc ? ACK_OK : w_set_cks ? ACK_CKS : ACK_CH;
  // Newest response overwrites an unconsumed one.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ack_data  <= '0;
      r_ack_valid <= 1'b0;
    end else if (w_ack_evt) begin
      r_ack_data  <= w_ack_code;
      r_ack_valid <= 1'b1;
    end else if (i_ack_ready) begin
      r_ack_valid <= 1'b0;
    end
  assign o_ack_data  = r_ack_data;
  assign o_ack_valid = r_ack_valid;
`endif
endmodule

// File: tb/tb_uart_cfg_mux_decoder.sv
// tb_uart_cfg_mux_decoder: scoreboard bench for the UART config decoder
module tb_uart_cfg_mux_decoder;
  typedef struct {int kind; int ch; int bps; int ds; int ss; int pm; int at;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [3:0] busy = '0;
  logic err_clear = 1'b0;
  logic [63:0] bps_div;
  logic [15:0] data_size;
  logic [23:0] stop_size;
  logic [7:0] parity_mode;
  logic [3:0] cfg_update;
  logic frame_ok, errc, errch, errto;
  logic p_c = 1'b0, p_ch = 1'b0, p_to = 1'b0;
  ev_t eq[$];
  ev_t sq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit done = 0, fin = 0;
`ifdef UART_CFG_ACK_EN
  logic [7:0] ack_data;
  logic ack_valid;
  logic [7:0] aq[$];
`endif
  uart_cfg_mux_decoder #(.NUM_CH(4), .TIMEOUT_CYC(200)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_ch_busy(busy), .i_err_clear(err_clear),
    .o_bps_div(bps_div), .o_data_size(data_size), .o_stop_size(stop_size),
    .o_parity_mode(parity_mode), .o_cfg_update(cfg_update), .o_frame_ok(frame_ok),
    .o_err_checksum(errc), .o_err_channel(errch), .o_err_timeout(errto)
`ifdef UART_CFG_ACK_EN
    , .o_ack_data(ack_data), .o_ack_valid(ack_valid), .i_ack_ready(1'b1)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic chan(input int c, input int bps, input int ds, input int ss, input int pm);
    chk($sformatf("ch%0d_bps_div", c), int'(bps_div[16*c +: 16]), bps);
    chk($sformatf("ch%0d_data_size", c), int'(data_size[4*c +: 4]), ds);
    chk($sformatf("ch%0d_stop_size", c), int'(stop_size[6*c +: 6]), ss);
    chk($sformatf("ch%0d_parity", c), int'(parity_mode[2*c +: 2]), pm);
  endtask
  task automatic take(input int kind, input int c);
    ev_t e;
    if (eq.size() == 0) begin
      chk("unexpected_event", kind * 16 + c, -1);
      return;
    end
    e = eq.pop_front();
    chk("event_kind", kind, e.kind);
    if (e.at >= 0) chk("event_cycle", cyc, e.at);
    if (kind == 1) begin
      chk("update_channel", c, e.ch);
      chan(c, e.bps, e.ds, e.ss, e.pm);
    end
  endtask
  always @(negedge clk) begin
    ev_t s;
    if (rst_n) begin
      if (frame_ok) take(0, 0);
      for (int i = 0; i < 4; i++) if (cfg_update[i]) take(1, i);
      if (errc && !p_c) take(2, 0);
      if (errch && !p_ch) take(3, 0);
      if (errto && !p_to) take(4, 0);
`ifdef UART_CFG_ACK_EN
      if (ack_valid) begin
        if (aq.size() == 0) chk("unexpected_ack", int'(ack_data), -1);
        else chk("ack_data", int'(ack_data), int'(aq.pop_front()));
      end
`endif
    end
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      s = sq.pop_front();
      if (s.kind == 5) chan(s.ch, s.bps, s.ds, s.ss, s.pm);
      else chk("flags", int'({frame_ok, cfg_update, errc, errch, errto}), s.bps);
    end
    if (done && !fin) begin
      chk("events_left", eq.size(), 0);
`ifdef UART_CFG_ACK_EN
      chk("acks_left", aq.size(), 0);
`endif
      fin = 1;
    end
    p_c <= errc;
    p_ch <= errch;
    p_to <= errto;
  end
  task automatic sb(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic snap_ch(input int c, input int bps, input int ds, input int ss, input int pm);
    sq.push_back('{5, c, bps, ds, ss, pm, cyc + 1});
  endtask
  task automatic snap_flags(input int f);
    sq.push_back('{6, 0, f, 0, 0, 0, cyc + 1});
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_err;
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask
  // res: 0 accept, 2 checksum error, 3 channel error
  task automatic frame(input logic [7:0] c, hi, lo, ck, input int res,
                       input int bps, input int ds, input int ss, input int pm);
    sb(8'hAA); sb(8'h55); sb(c); sb(hi); sb(lo); sb(ck);
    @(negedge clk);
    if (res == 0) begin
      eq.push_back('{0, 0, 0, 0, 0, 0, cyc + 1});
      if (!busy[c[1:0]]) eq.push_back('{1, int'(c), bps, ds, ss, pm, cyc + 1});
    end else eq.push_back('{res, 0, 0, 0, 0, 0, cyc + 1});
`ifdef UART_CFG_ACK_EN
    aq.push_back(res == 0 ? 8'hAC : res == 2 ? 8'hE1 : 8'hE2);
`endif
    rx_data = 8'h55;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  initial begin
    idle(3);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) snap_ch(c, 325, 8, 16, 0);
    snap_flags(0);
    idle(3);
    frame(8'h02, 8'h0D, 8'h3A, 8'h49, 0, 27, 8, 32, 2);
    idle(3);
    snap_ch(0, 325, 8, 16, 0);
    snap_ch(1, 325, 8, 16, 0);
    snap_ch(3, 325, 8, 16, 0);
    idle(3);
    busy = 4'b0100;
    frame(8'h02, 8'h01, 8'h25, 8'h28, 0, 0, 0, 0, 0);
    frame(8'h02, 8'h0F, 8'h1C, 8'h2D, 0, 0, 0, 0, 0);
    idle(50);
    snap_ch(2, 27, 8, 32, 2);
    idle(2);
    eq.push_back('{1, 2, 12, 6, 16, 0, cyc + 1});
    busy = 4'b0000;
    idle(3);
    snap_ch(2, 12, 6, 16, 0);
    idle(2);
    frame(8'h01, 8'h06, 8'h30, 8'h00, 2, 0, 0, 0, 0);
    idle(3);
    snap_flags(4);
    idle(2);
    clear_err;
    snap_flags(0);
    idle(2);
    frame(8'h07, 8'h06, 8'h30, 8'h3D, 3, 0, 0, 0, 0);
    idle(3);
    snap_flags(2);
    idle(2);
    clear_err;
    snap_flags(0);
    idle(2);
    sb(8'hAA);
    frame(8'h01, 8'h06, 8'h30, 8'h37, 0, 325, 8, 16, 0);
    idle(3);
    eq.push_back('{4, 0, 0, 0, 0, 0, -1});
`ifdef UART_CFG_ACK_EN
    aq.push_back(8'hE3);
`endif
    sb(8'hAA); sb(8'h55); sb(8'h01);
    idle(300);
    snap_flags(1);
    idle(2);
    clear_err;
    frame(8'h03, 8'h0D, 8'h3A, 8'h4A, 0, 27, 8, 32, 2);
    idle(5);
    snap_flags(0);
    idle(2);
    done = 1;
    for (int i = 0; i < 10 && !fin; i++) @(negedge clk);
    if (!fin) begin
      n_bad++;
      $display("FAIL monitor_finish: got 0 expected 1");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
